color_analyzer: RTL and testbench

//  Frame-buffer colour analyser, parametrised successor of the single-channel-sum analyser.

---
 rtl/color_analyzer_pkg.sv | 31 +++
 rtl/color_analyzer_acc.sv | 29 ++
 rtl/color_analyzer.sv | 192 +++++++++++++++++++
 tb/tb_color_analyzer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_analyzer_pkg.sv
// Shared types for the RGB332 colour analyser: FSM encoding, result codes and
// channel extraction helpers.
package color_analyzer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    DECIDE,
    DONE
  } state_t;

  localparam logic [2:0] RES_R    = 3'b100;
  localparam logic [2:0] RES_G    = 3'b010;
  localparam logic [2:0] RES_B    = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b111;

  function automatic logic [2:0] px_r(input logic [7:0] px);
    return px[7:5];
  endfunction

  function automatic logic [2:0] px_g(input logic [7:0] px);
    return px[4:2];
  endfunction

  // Blue is only 2 bits; replicating its MSB gives a 0..7 scale like R and G.
  function automatic logic [2:0] px_b(input logic [7:0] px);
    return {px[1:0], px[1]};
  endfunction

endpackage

// File: rtl/color_analyzer_acc.sv
// Saturating unsigned channel accumulator with synchronous clear and enable.
module color_analyzer_acc #(
  parameter int SUM_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       sample,
  output logic [SUM_W-1:0] sum
);

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                input logic [2:0]       b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W-2){1'b0}}, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum <= '0;
    else if (clr)
      sum <= '0;
    else if (en)
      sum <= sat_add(sum, sample);
  end

endmodule

// File: rtl/color_analyzer.sv
// Frame-buffer colour analyser: scans an RGB332 frame, sums each channel and
// reports the dominant one. Optional region of interest: COLOR_ANALYZER_ROI_EN.
module color_analyzer
  import color_analyzer_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1,
  parameter int SUM_W  = 18,
  parameter int MARGIN = 0,
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  input  logic [7:0]        data,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [2:0]        res,
`ifdef COLOR_ANALYZER_ROI_EN
  input  logic [XW-1:0]     roi_x0,
  input  logic [XW-1:0]     roi_x1,
  input  logic [YW-1:0]     roi_y0,
  input  logic [YW-1:0]     roi_y1,
`endif
  output logic [SUM_W-1:0]  sum_r,
  output logic [SUM_W-1:0]  sum_g,
  output logic [SUM_W-1:0]  sum_b
);

  localparam int N  = IMG_W * IMG_H;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  state_t            state;
  logic [DW-1:0]     drain_cnt;
  logic [RD_LAT-1:0] vld_p;
  logic              abort_act;
  logic              clr_sums;
  logic              acc_en;
  logic [2:0]        decision;

  assign abort_act = abort && (state == SCAN || state == DRAIN || state == DECIDE);
  assign clr_sums  = (state == IDLE) && start;

  // FSM, address generator and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res       <= 3'b000;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort_act) begin
        state <= IDLE;
        addr  <= '0;
        rd_en <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state     <= SCAN;
            addr      <= '0;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
            res_valid <= 1'b0;
          end
          SCAN: if (addr == LAST_ADDR) begin
            state     <= DRAIN;
            addr      <= '0;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
          DRAIN: if (drain_cnt == DW'(RD_LAT - 1))
            state <= DECIDE;
          else
            drain_cnt <= drain_cnt + 1'b1;
          DECIDE: begin
            state     <= DONE;
            res       <= decision;
            busy      <= 1'b0;
            done      <= 1'b1;
            res_valid <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read-valid pipe p0..p(RD_LAT-1); last tap lines up with data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (abort_act) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++)
        vld_p[i] <= vld_p[i-1];
    end
  end

`ifdef COLOR_ANALYZER_ROI_EN
  logic [XW-1:0] x_cnt, win_x0, win_x1;
  logic [YW-1:0] y_cnt, win_y0, win_y1;
  logic [XW-1:0] x_p [RD_LAT];
  logic [YW-1:0] y_p [RD_LAT];
  logic          in_win;

  // Pixel coordinates follow addr; window bounds are frozen at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (clr_sums || abort_act || (state == SCAN && addr == LAST_ADDR)) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == SCAN) begin
      if (x_cnt == XW'(IMG_W - 1)) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_sums) begin
      win_x0 <= roi_x0;
      win_x1 <= roi_x1;
      win_y0 <= roi_y0;
      win_y1 <= roi_y1;
    end
    x_p[0] <= x_cnt;
    y_p[0] <= y_cnt;
    for (int i = 1; i < RD_LAT; i++) begin
      x_p[i] <= x_p[i-1];
      y_p[i] <= y_p[i-1];
    end
  end

  assign in_win = (x_p[RD_LAT-1] >= win_x0) && (x_p[RD_LAT-1] <= win_x1) &&
                  (y_p[RD_LAT-1] >= win_y0) && (y_p[RD_LAT-1] <= win_y1);
  assign acc_en = vld_p[RD_LAT-1] && in_win;
`else
  assign acc_en = vld_p[RD_LAT-1];
`endif

  color_analyzer_acc #(.SUM_W(SUM_W)) u_acc_r (
    .clk(clk), .rst_n(rst_n), .clr(clr_sums), .en(acc_en), .sample(px_r(data)), .sum(sum_r)
  );
  color_analyzer_acc #(.SUM_W(SUM_W)) u_acc_g (
    .clk(clk), .rst_n(rst_n), .clr(clr_sums), .en(acc_en), .sample(px_g(data)), .sum(sum_g)
  );
  color_analyzer_acc #(.SUM_W(SUM_W)) u_acc_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_sums), .en(acc_en), .sample(px_b(data)), .sum(sum_b)
  );

  // One extra bit keeps sum + MARGIN from wrapping
  logic [SUM_W:0] wr, wg, wb, wm;
  assign wr = {1'b0, sum_r};
  assign wg = {1'b0, sum_g};
  assign wb = {1'b0, sum_b};
  assign wm = (SUM_W+1)'(MARGIN);

  always_comb begin
    decision = RES_NONE;
    if (wr > wg + wm && wr > wb + wm)
      decision = RES_R;
    else if (wg > wr + wm && wg > wb + wm)
      decision = RES_G;
    else if (wb > wr + wm && wb > wg + wm)
      decision = RES_B;
  end

endmodule

// File: tb/tb_color_analyzer.sv
// Scoreboard bench for color_analyzer: three instances (read latency / margin
// variants) share one frame and one stimulus stream.
`timescale 1ns/1ps
module tb_color_analyzer;
  import color_analyzer_pkg::*;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int N      = IMG_W * IMG_H;
  localparam int ADDR_W = 3;
  localparam int SUM_W  = 18;
  localparam int NI     = 3;

  typedef struct {
    int         sr;
    int         sg;
    int         sb;
    logic [2:0] res;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]        mem [N];
  logic [ADDR_W-1:0] addr_w [NI];
  logic              rd_en_w [NI];
  logic              busy_w [NI];
  logic              done_w [NI];
  logic              res_valid_w [NI];
  logic [2:0]        res_w [NI];
  logic [SUM_W-1:0]  sr_w [NI];
  logic [SUM_W-1:0]  sg_w [NI];
  logic [SUM_W-1:0]  sb_w [NI];

`ifdef COLOR_ANALYZER_ROI_EN
  logic [1:0] rx0 = 2'd0, rx1 = 2'd3;
  logic [0:0] ry0 = 1'b0, ry1 = 1'b1;
`endif

  exp_t sbq [NI][$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  function automatic int margin_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 27 : 28);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: plain per-pixel sums over the window, then the dominance rule.
  function automatic exp_t model(input int g);
    exp_t e;
    int   x, y, smax;
    bit   inw;
    e.sr = 0; e.sg = 0; e.sb = 0;
    smax = (1 << SUM_W) - 1;
    for (int i = 0; i < N; i++) begin
      x = i % IMG_W;
      y = i / IMG_W;
      inw = 1'b1;
`ifdef COLOR_ANALYZER_ROI_EN
      inw = (x >= int'(rx0)) && (x <= int'(rx1)) && (y >= int'(ry0)) && (y <= int'(ry1));
`endif
      if (inw) begin
        e.sr += int'(mem[i] >> 5);
        e.sg += int'(mem[i] >> 2) % 8;
        e.sb += (int'(mem[i]) % 4) * 2 + (int'(mem[i]) % 4) / 2;
      end
    end
    if (e.sr > smax) e.sr = smax;
    if (e.sg > smax) e.sg = smax;
    if (e.sb > smax) e.sb = smax;
    if (e.sr > e.sg + margin_of(g) && e.sr > e.sb + margin_of(g))      e.res = 3'b100;
    else if (e.sg > e.sr + margin_of(g) && e.sg > e.sb + margin_of(g)) e.res = 3'b010;
    else if (e.sb > e.sr + margin_of(g) && e.sb > e.sg + margin_of(g)) e.res = 3'b001;
    else                                                               e.res = 3'b111;
    e.lat = N + lat_of(g) + 2;
    return e;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = (g == 2) ? 3 : 1;
    localparam int M = (g == 0) ? 0 : ((g == 1) ? 27 : 28);
    logic [7:0] rpipe [L];
    logic       done_q = 1'b0;
    int         exp_addr = 0;

    color_analyzer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RD_LAT(L), .SUM_W(SUM_W), .MARGIN(M)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .addr(addr_w[g]), .rd_en(rd_en_w[g]), .data(rpipe[L-1]),
      .busy(busy_w[g]), .done(done_w[g]), .res_valid(res_valid_w[g]), .res(res_w[g]),
`ifdef COLOR_ANALYZER_ROI_EN
      .roi_x0(rx0), .roi_x1(rx1), .roi_y0(ry0), .roi_y1(ry1),
`endif
      .sum_r(sr_w[g]), .sum_g(sg_w[g]), .sum_b(sb_w[g])
    );

    // Synchronous RAM: garbage on the bus whenever no read was issued
    always @(posedge clk) begin
      rpipe[0] <= rd_en_w[g] ? mem[addr_w[g]] : 8'($urandom);
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        exp_addr = 0;
        done_q <= 1'b0;
      end else begin
        if (rd_en_w[g]) begin
          chk($sformatf("u%0d.addr_seq", g), addr_w[g], exp_addr);
          chk($sformatf("u%0d.rd_en_in_busy", g), busy_w[g], 1);
          exp_addr++;
        end else begin
          chk($sformatf("u%0d.addr_idle", g), addr_w[g], 0);
          exp_addr = 0;
        end
        if (done_q) chk($sformatf("u%0d.done_width", g), done_w[g], 0);
        if (done_w[g]) begin
          chk($sformatf("u%0d.done_expected", g), int'(sbq[g].size() != 0), 1);
          if (sbq[g].size() != 0) begin
            exp_t e;
            e = sbq[g].pop_front();
            chk($sformatf("u%0d.sum_r", g), sr_w[g], e.sr);
            chk($sformatf("u%0d.sum_g", g), sg_w[g], e.sg);
            chk($sformatf("u%0d.sum_b", g), sb_w[g], e.sb);
            chk($sformatf("u%0d.res", g), res_w[g], e.res);
            chk($sformatf("u%0d.res_valid", g), res_valid_w[g], 1);
            chk($sformatf("u%0d.busy_at_done", g), busy_w[g], 0);
            chk($sformatf("u%0d.latency", g), cyc - start_cyc + 1, e.lat);
          end
        end
        done_q <= done_w[g];
      end
    end
  end

  task automatic chk_reset(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s.u%0d.addr", tag, g), addr_w[g], 0);
      chk($sformatf("%s.u%0d.rd_en", tag, g), rd_en_w[g], 0);
      chk($sformatf("%s.u%0d.busy", tag, g), busy_w[g], 0);
      chk($sformatf("%s.u%0d.done", tag, g), done_w[g], 0);
      chk($sformatf("%s.u%0d.res_valid", tag, g), res_valid_w[g], 0);
      chk($sformatf("%s.u%0d.res", tag, g), res_w[g], 0);
      chk($sformatf("%s.u%0d.sums", tag, g), sr_w[g] | sg_w[g] | sb_w[g], 0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    bit idle;
    do begin
      @(negedge clk);
      #1;
      idle = 1'b1;
      for (int g = 0; g < NI; g++)
        if (busy_w[g] || done_w[g] || sbq[g].size() != 0) idle = 1'b0;
      n++;
    end while (!idle && n < 300);
    chk("idle_reached", int'(idle), 1);
  endtask

  task automatic push_all();
    for (int g = 0; g < NI; g++) sbq[g].push_back(model(g));
  endtask

  // Issue start, log the accept edge, optionally pulse start again mid-scan.
  task automatic run_frame(input bit push, input bit restart_pulse);
`ifdef COLOR_ANALYZER_ROI_EN
    logic [1:0] sx0, sx1;
    logic [0:0] sy0, sy1;
`endif
    @(negedge clk);
    start = 1'b1;
    if (push) push_all();
    @(posedge clk);
    #1 start_cyc = cyc;
    start = 1'b0;
`ifdef COLOR_ANALYZER_ROI_EN
    sx0 = rx0; sx1 = rx1; sy0 = ry0; sy1 = ry1;
    rx0 = 2'($urandom); rx1 = 2'($urandom); ry0 = 1'($urandom); ry1 = 1'($urandom);
`endif
    if (restart_pulse) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
`ifdef COLOR_ANALYZER_ROI_EN
    rx0 = sx0; rx1 = sx1; ry0 = sy0; ry1 = sy1;
`endif
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < N; i++) mem[i] = (i < N/2) ? a : b;
  endtask

  logic [7:0] masks [7] = '{8'hFF, 8'hE3, 8'h1F, 8'hFC, 8'hE0, 8'h1C, 8'h03};

  initial begin
    fill(8'h00, 8'h00);
    #12 chk_reset("por");
    @(negedge clk) rst_n = 1'b1;

    fill(8'hE0, 8'hE0);   run_frame(1'b1, 1'b0);
    fill(8'h1C, 8'h03);   run_frame(1'b1, 1'b0);
    fill(8'h1C, 8'h1C);   run_frame(1'b1, 1'b0);
    fill(8'h00, 8'h00);   run_frame(1'b1, 1'b0);
    fill(8'hFF, 8'hFF);   run_frame(1'b1, 1'b0);

    // Abort sampled on the edge that ends SCAN cycle 3
    fill(8'hE0, 8'h1C);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("abort.u%0d.busy", g), busy_w[g], 0);
      chk($sformatf("abort.u%0d.rd_en", g), rd_en_w[g], 0);
      chk($sformatf("abort.u%0d.res_valid", g), res_valid_w[g], 0);
    end
    repeat (20) @(negedge clk);
    run_frame(1'b1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      logic [7:0] m;
      m = masks[$urandom_range(6, 0)];
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom) & m;
      run_frame(1'b1, 1'b0);
    end

    // Asynchronous reset while the RD_LAT=3 instance is draining
    fill(8'hFF, 8'hFF);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (N + 1) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset("drain_rst");
    @(negedge clk) rst_n = 1'b1;
    fill(8'h03, 8'h03);   run_frame(1'b1, 1'b0);

`ifdef COLOR_ANALYZER_ROI_EN
    fill(8'hE0, 8'hE0);
    rx0 = 2'd1; rx1 = 2'd2; ry0 = 1'b1; ry1 = 1'b1;  run_frame(1'b1, 1'b0);
    rx0 = 2'd3; rx1 = 2'd1; ry0 = 1'b0; ry1 = 1'b1;  run_frame(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      rx0 = 2'($urandom); rx1 = 2'($urandom); ry0 = 1'($urandom); ry1 = 1'($urandom);
      run_frame(1'b1, 1'b0);
    end
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
